// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualification and synchronous core reset release
// Define PLL_RST_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_W              = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic                  rst_n_out,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_n_out_q, rst_n_out_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], locked};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        // Any dropout restarts qualification from scratch.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (soft_rst_req) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Registered from the next state so the core reset is glitch-free and aligned with state.
    rst_n_out_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sync_q      <= '0;
      rst_n_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      rst_n_out_q <= rst_n_out_d;
    end
  end

  assign state     = state_q;
  assign rst_n_out = rst_n_out_q;
  assign ready     = rst_n_out_q;

`ifdef PLL_RST_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == RUN && !locked_s && loss_q != {LOSS_CNT_W{1'b1}}) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed and randomized checks of pll_reset_sequencer
// Reference model works from run lengths of synchronized lock and hold restarts.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int LSC    = 8;
  localparam int RHC    = 4;
  localparam int LOSS_W = 2;
  localparam int LOSS_MAX = (1 << LOSS_W) - 1;

  logic              CLK;
  logic              RST_N;
  logic              locked;
  logic              soft_rst_req;
  logic              rst_n_out;
  logic              ready;
  logic [1:0]        state;
  logic [LOSS_W-1:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES(RHC),
    .CNT_W(16),
    .LOSS_CNT_W(LOSS_W)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .locked(locked),
    .soft_rst_req(soft_rst_req),
    .rst_n_out(rst_n_out),
    .ready(ready),
    .state(state),
    .lock_loss_count(lock_loss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: lq delays raw locked samples; m_run counts consecutive qualified-high edges;
  // m_since counts edges since the hold phase last (re)started.
  logic        lq[$];
  int          m_run;
  int          m_since;
  int          m_loss;
  logic [1:0]  m_state;

  task automatic model_reset();
    lq.delete();
    for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
    m_run   = 0;
    m_since = 0;
    m_loss  = 0;
    m_state = 2'd0;
  endtask

  task automatic model_edge();
    logic l;
    if (!RST_N) begin
      model_reset();
      return;
    end
    l = lq.pop_front();
    lq.push_back(locked);
    if (!l) begin
      if (m_state == 2'd3 && m_loss < LOSS_MAX) m_loss++;
      m_run   = 0;
      m_since = 0;
      m_state = 2'd0;
    end else begin
      if (m_run < 1000000) m_run++;
      if (m_run <= LSC) begin
        m_state = 2'd1;
      end else begin
        if (m_run == LSC + 1 || soft_rst_req) m_since = 0;
        else if (m_since < RHC) m_since++;
        m_state = (m_since >= RHC) ? 2'd3 : 2'd2;
      end
    end
  endtask

  always @(posedge CLK) model_edge();
  always @(negedge RST_N) model_reset();

  function automatic logic [LOSS_W-1:0] lc(input int n);
`ifdef PLL_RST_LOCK_LOSS_CNT_EN
    return (n > LOSS_MAX) ? LOSS_W'(LOSS_MAX) : LOSS_W'(n);
`else
    return (n < 0) ? LOSS_W'(1) : '0;
`endif
  endfunction

  task automatic expect_out(input string tag, input logic [1:0] es, input logic er,
                            input logic [LOSS_W-1:0] el);
    checks++;
    assert (state === es) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
    end
    checks++;
    assert (rst_n_out === er) else begin
      errors++;
      $error("FAIL %s rst_n_out: observed %0b expected %0b", tag, rst_n_out, er);
    end
    checks++;
    assert (ready === er) else begin
      errors++;
      $error("FAIL %s ready: observed %0b expected %0b", tag, ready, er);
    end
    checks++;
    assert (lock_loss_count === el) else begin
      errors++;
      $error("FAIL %s lock_loss_count: observed %0d expected %0d", tag, lock_loss_count, el);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      expect_out("model", m_state, m_state == 2'd3, lc(m_loss));
    end
  endtask

  initial begin
    model_reset();
    RST_N        = 1'b0;
    locked       = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge CLK);
    expect_out("reset", 2'd0, 1'b0, lc(0));
    RST_N = 1'b1;
    tick(2);
    expect_out("unlocked idle", 2'd0, 1'b0, lc(0));

    // Clean start: edge 1 is the first edge sampling locked=1.
    locked = 1'b1;
    tick(2);
    expect_out("clean e2", 2'd0, 1'b0, lc(0));
    tick(1);
    expect_out("clean e3", 2'd1, 1'b0, lc(0));
    tick(7);
    expect_out("clean e10", 2'd1, 1'b0, lc(0));
    tick(1);
    expect_out("clean e11", 2'd2, 1'b0, lc(0));
    tick(3);
    expect_out("clean e14", 2'd2, 1'b0, lc(0));
    tick(1);
    expect_out("clean e15", 2'd3, 1'b1, lc(0));

    // Soft reset held for three samples.
    soft_rst_req = 1'b1;
    tick(1);
    expect_out("soft first", 2'd2, 1'b0, lc(0));
    tick(2);
    soft_rst_req = 1'b0;
    tick(3);
    expect_out("soft hold", 2'd2, 1'b0, lc(0));
    tick(1);
    expect_out("soft release", 2'd3, 1'b1, lc(0));

    // Lock loss in RUN, then relock.
    locked = 1'b0;
    tick(2);
    expect_out("loss e2", 2'd3, 1'b1, lc(0));
    tick(1);
    expect_out("loss e3", 2'd0, 1'b0, lc(1));
    locked = 1'b1;
    tick(14);
    expect_out("relock e14", 2'd2, 1'b0, lc(1));
    tick(1);
    expect_out("relock e15", 2'd3, 1'b1, lc(1));

    // Glitch seen by the FSM while cnt=5 in STABILIZE.
    locked = 1'b0;
    tick(3);
    expect_out("glitch pre", 2'd0, 1'b0, lc(2));
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    expect_out("glitch e8", 2'd1, 1'b0, lc(2));
    tick(1);
    expect_out("glitch drop", 2'd0, 1'b0, lc(2));
    tick(1);
    expect_out("glitch requal", 2'd1, 1'b0, lc(2));
    tick(7);
    expect_out("glitch stab8", 2'd1, 1'b0, lc(2));
    tick(1);
    expect_out("glitch hold", 2'd2, 1'b0, lc(2));
    tick(4);
    expect_out("glitch run", 2'd3, 1'b1, lc(2));

    // Asynchronous reset asserted mid-cycle while in HOLD.
    soft_rst_req = 1'b1;
    tick(2);
    expect_out("pre async", 2'd2, 1'b0, lc(2));
    #2 RST_N = 1'b0;
    #1 expect_out("async immediate", 2'd0, 1'b0, lc(0));
    soft_rst_req = 1'b0;
    @(negedge CLK);
    expect_out("async held", 2'd0, 1'b0, lc(0));
    RST_N = 1'b1;
    tick(14);
    expect_out("async reseq e14", 2'd2, 1'b0, lc(0));
    tick(1);
    expect_out("async reseq e15", 2'd3, 1'b1, lc(0));

    // Five losses from RUN; counter saturates.
    for (int i = 0; i < 5; i++) begin
      locked = 1'b0;
      tick(3);
      expect_out("sat loss", 2'd0, 1'b0, lc(i + 1));
      locked = 1'b1;
      tick(15);
      expect_out("sat relock", 2'd3, 1'b1, lc(i + 1));
    end

    // Randomized lock dropouts and soft requests against the model.
    for (int i = 0; i < 1500; i++) begin
      locked       = ($urandom_range(0, 99) < 96);
      soft_rst_req = ($urandom_range(0, 15) == 0);
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer sitting directly downstream of the board PLL. It synchronizes the PLL's asynchronous `locked` flag into the system clock domain and requires lock to stay stable for a programmable time. It then holds the design in reset for a further programmable time before releasing a synchronously-deasserted reset to the ray-tracing core. Loss of lock, or a soft reset request, re-enters the sequence.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `locked`; must be ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-high cycles of `locked` required; must be ≥1.
- `RESET_HOLD_CYCLES`, 16: cycles reset stays asserted after lock is qualified; must be ≥1.
- `CNT_W`, 16: phase counter width; both cycle parameters must be < 2^CNT_W.
- `LOSS_CNT_W`, 8: lock-loss counter width.

Ports:
- `CLK` in 1: system clock, the PLL output consumed by the core.
- `RST_N` in 1: reset, asynchronous assert, active-low (power-on/button).
- `locked` in 1: PLL lock flag, asynchronous to `CLK`.
- `soft_rst_req` in 1: synchronous level request to re-run the hold phase.
- `rst_n_out` out 1: core reset, active-low; deasserts synchronously to `CLK`.
- `ready` out 1: high exactly when `rst_n_out` is high.
- `state` out 2: current state; WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
- `lock_loss_count` out LOSS_CNT_W: count of RUN→WAIT_LOCK transitions, saturating.

## Operation
- `locked` passes through a chain of `SYNC_STAGES` flops. Output `locked_s` comes from the last flop. All flops clear to 0 on reset.
- Phase counter `cnt` has width CNT_W.
- WAIT_LOCK:
  - `cnt`=0.
  - If `locked_s`=1, go to STABILIZE.
- STABILIZE:
  - If `locked_s`=0, go to WAIT_LOCK with `cnt`=0. A glitch fully restarts qualification.
  - Else if `cnt`==LOCK_STABLE_CYCLES-1, go to HOLD with `cnt`=0.
  - Else increment `cnt`.
- HOLD:
  - If `locked_s`=0, go to WAIT_LOCK.
  - Else if `soft_rst_req`=1, stay with `cnt`=0.
  - Else if `cnt`==RESET_HOLD_CYCLES-1, go to RUN.
  - Else increment `cnt`.
- RUN:
  - If `locked_s`=0, go to WAIT_LOCK and increment `lock_loss_count`.
  - Else if `soft_rst_req`=1, go to HOLD with `cnt`=0.
- Priority: lock loss beats `soft_rst_req` in every state. `soft_rst_req` is ignored in WAIT_LOCK and STABILIZE.
- `rst_n_out` and `ready` are registered and equal (next state == RUN). They change on the same edge as `state`. They never glitch.
- `lock_loss_count` saturates at all-ones and is never cleared except by `RST_N`.

## Timing
- Reset values while `RST_N`=0, applied immediately and asynchronously:
  - `state`=WAIT_LOCK, `cnt`=0
  - `rst_n_out`=0, `ready`=0
  - `lock_loss_count`=0
  - synchronizer flops = 0
- Release latency: with `locked` continuously high, `rst_n_out` rises on edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES. Edge 1 is the first edge that samples `locked`=1.
- Lock-loss latency: `rst_n_out` falls on edge SYNC_STAGES+1 after the first edge sampling `locked`=0.
- Soft reset: `rst_n_out` falls on the first edge sampling `soft_rst_req`=1 in RUN. It rises RESET_HOLD_CYCLES edges after the last edge sampling it high.
- `RST_N` deasserting is not synchronized here. The top level drives `RST_N` from a power-on synchronizer.

## Configuration
- `PLL_RST_LOCK_LOSS_CNT_EN` defined: `lock_loss_count` register and increment logic are present as described.
- `PLL_RST_LOCK_LOSS_CNT_EN` not defined: no counter flops; `lock_loss_count` is tied to 0. All other behaviour is identical.

## Test plan
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, LOSS_CNT_W=2, macro defined.
- Clean start: release `RST_N`, raise `locked`.
  - `state` goes 0→1 on edge 3, 1→2 on edge 11, 2→3 on edge 15.
  - `rst_n_out`=`ready`=1 from edge 15.
- Glitch: drop `locked` for one cycle while in STABILIZE at `cnt`=5.
  - `state` returns to 0, then full requalification: 8 more STABILIZE cycles before HOLD.
- Lock loss in RUN: drop `locked`.
  - `rst_n_out`=0 and `state`=0 on edge 3 after the drop; `lock_loss_count`=1.
  - After relock, release again after 15 edges.
- Soft reset: pulse `soft_rst_req` for 3 cycles in RUN.
  - `rst_n_out` falls on the first edge; `state`=2.
  - Release 4 edges after the last high sample.
  - `lock_loss_count` unchanged.
- Saturation: cause 5 lock losses from RUN → `lock_loss_count` stays 3 after the 3rd.
- Async reset in HOLD: assert `RST_N` mid-cycle.
  - All outputs at reset values before the next edge.
  - After release, full 15-edge sequence repeats.
